// File: rtl/reg8_serial_tx.sv
// reg8_serial_tx: valid/ready parallel-in, start/data/stop serial-out frame transmitter.
// Define REG8_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module reg8_serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          LSB_FIRST    = 1'b1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] D,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef REG8_SERIAL_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [CW-1:0]    cyc_cnt, cyc_nxt;
    logic             tx_nxt, ready_nxt, busy_nxt, done_nxt;
`ifdef REG8_SERIAL_TX_PARITY_EN
    logic             par_bit, par_nxt;
`endif

    logic             bit_end;
    logic             head;
    logic [WIDTH-1:0] shifted;

    // Next serial bit sits at the head of the shift register; shifting exposes the one after it.
    assign bit_end = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
    assign head    = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
    assign shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            tx_out   <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef REG8_SERIAL_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_nxt;
            cyc_cnt  <= cyc_nxt;
            tx_out   <= tx_nxt;
            in_ready <= ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
`ifdef REG8_SERIAL_TX_PARITY_EN
            par_bit  <= par_nxt;
`endif
        end
    end

    // Outputs are computed one cycle ahead so tx_out changes on the same edge as the state.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        cyc_nxt   = cyc_cnt;
        tx_nxt    = tx_out;
        ready_nxt = in_ready;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
`ifdef REG8_SERIAL_TX_PARITY_EN
        par_nxt   = par_bit;
`endif
        if (state != IDLE) begin
            cyc_nxt = bit_end ? '0 : cyc_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt = START;
                    shreg_nxt = D;
                    bit_nxt   = '0;
                    cyc_nxt   = '0;
                    tx_nxt    = 1'b0;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef REG8_SERIAL_TX_PARITY_EN
                    par_nxt   = ^D;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = head;
                    shreg_nxt = shifted;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef REG8_SERIAL_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + BW'(1);
                        tx_nxt    = head;
                        shreg_nxt = shifted;
                    end
                end
            end
`ifdef REG8_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_reg8_serial_tx.sv
// Directed bench for reg8_serial_tx: default instance plus an MSB-first, one-clock-per-bit instance.
// Build with REG8_SERIAL_TX_PARITY_EN defined to cover the parity frame layout.
module tb_reg8_serial_tx;
`ifdef REG8_SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       in_valid, in_ready, tx_out, busy, done;
    logic [7:0] d;
    logic       in_valid2, in_ready2, tx2, busy2, done2;
    logic [7:0] d2;

    int checks = 0;
    int errors = 0;

    reg8_serial_tx dut (
        .CLK(clk), .reset(reset), .in_valid(in_valid), .D(d),
        .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    reg8_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(clk), .reset(reset), .in_valid(in_valid2), .D(d2),
        .in_ready(in_ready2), .tx_out(tx2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; d = 8'hAA; in_valid2 = 1'b1; d2 = 8'h55;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (tx_out !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b want 1", tx_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({tx2, in_ready2, busy2, done2} !== 4'b1100)
            begin errors++; $display("FAIL reset_msb_outs: got %b want 1100", {tx2, in_ready2, busy2, done2}); end
        reset = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || tx_out !== 1'b1)
            begin errors++; $display("FAIL reset_no_capture: busy %b tx %b want 0 1", busy, tx_out); end
    endtask

    task automatic test_idle();
        for (int n = 0; n < 20; n++) begin
            checks++;
            if ({tx_out, in_ready, busy, done} !== 4'b1100)
                begin errors++; $display("FAIL idle_c%0d: got %b want 1100", n, {tx_out, in_ready, busy, done}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_frame_a5();
        int exp_bits [NBITS];
`ifdef REG8_SERIAL_TX_PARITY_EN
        exp_bits = '{0,1,0,1,0,0,1,0,1,0,1};
`else
        exp_bits = '{0,1,0,1,0,0,1,0,1,1};
`endif
        in_valid = 1'b1; d = 8'hA5;
        @(posedge clk); #1;
        in_valid = 1'b0; d = 8'h00;
        for (int n = 0; n < NBITS*CPB; n++) begin
            checks++;
            if (tx_out !== exp_bits[n/CPB][0] || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0)
                begin errors++; $display("FAIL a5_c%0d: tx/busy/done/rdy %b%b%b%b want %b100",
                      n, tx_out, busy, done, in_ready, exp_bits[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++;
        if ({done, busy, in_ready, tx_out} !== 4'b1011)
            begin errors++; $display("FAIL a5_done: done/busy/rdy/tx %b want 1011", {done, busy, in_ready, tx_out}); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL a5_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_msb_first();
        int exp_bits [NBITS];
`ifdef REG8_SERIAL_TX_PARITY_EN
        exp_bits = '{0,1,0,0,0,0,0,0,1,0,1};
`else
        exp_bits = '{0,1,0,0,0,0,0,0,1,1};
`endif
        in_valid2 = 1'b1; d2 = 8'h81;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        for (int n = 0; n < NBITS; n++) begin
            checks++;
            if (tx2 !== exp_bits[n][0] || busy2 !== 1'b1 || done2 !== 1'b0)
                begin errors++; $display("FAIL msb_c%0d: tx/busy/done %b%b%b want %b10",
                      n, tx2, busy2, done2, exp_bits[n][0]); end
            @(posedge clk); #1;
        end
        checks++;
        if ({done2, busy2, in_ready2} !== 3'b101)
            begin errors++; $display("FAIL msb_done: done/busy/rdy %b want 101", {done2, busy2, in_ready2}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int exp_a [NBITS];
        int exp_b [NBITS];
`ifdef REG8_SERIAL_TX_PARITY_EN
        exp_a = '{0,0,0,1,1,1,1,0,0,0,1};
        exp_b = '{0,1,1,1,1,1,1,1,1,0,1};
`else
        exp_a = '{0,0,0,1,1,1,1,0,0,1};
        exp_b = '{0,1,1,1,1,1,1,1,1,1};
`endif
        in_valid = 1'b1; d = 8'h3C;
        @(posedge clk); #1;
        d = 8'hFF;
        for (int n = 0; n < NBITS*CPB; n++) begin
            checks++;
            if (tx_out !== exp_a[n/CPB][0] || in_ready !== 1'b0 || done !== 1'b0)
                begin errors++; $display("FAIL b2b_a_c%0d: tx/rdy/done %b%b%b want %b00",
                      n, tx_out, in_ready, done, exp_a[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++;
        if ({done, in_ready, tx_out} !== 3'b111)
            begin errors++; $display("FAIL b2b_a_done: done/rdy/tx %b want 111", {done, in_ready, tx_out}); end
        @(posedge clk); #1;
        for (int n = 0; n < NBITS*CPB; n++) begin
            checks++;
            if (tx_out !== exp_b[n/CPB][0] || busy !== 1'b1 || done !== 1'b0)
                begin errors++; $display("FAIL b2b_b_c%0d: tx/busy/done %b%b%b want %b10",
                      n, tx_out, busy, done, exp_b[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++;
        if ({done, busy} !== 2'b10)
            begin errors++; $display("FAIL b2b_b_done: done/busy %b want 10", {done, busy}); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1)
            begin errors++; $display("FAIL b2b_idle: busy %b tx %b want 0 1", busy, tx_out); end
    endtask

    task automatic test_reset_mid_frame();
        int exp_bits [NBITS];
`ifdef REG8_SERIAL_TX_PARITY_EN
        exp_bits = '{0,1,1,1,1,0,0,0,0,0,1};
`else
        exp_bits = '{0,1,1,1,1,0,0,0,0,1};
`endif
        in_valid = 1'b1; d = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 17; n++) begin
            @(posedge clk); #1;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({tx_out, in_ready, busy, done} !== 4'b1100)
            begin errors++; $display("FAIL abort_outs: got %b want 1100", {tx_out, in_ready, busy, done}); end
        for (int n = 0; n < NBITS*CPB; n++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL abort_quiet_c%0d: done %b busy %b want 0 0", n, done, busy); end
            @(posedge clk); #1;
        end
        in_valid = 1'b1; d = 8'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < NBITS*CPB; n++) begin
            checks++;
            if (tx_out !== exp_bits[n/CPB][0] || done !== 1'b0)
                begin errors++; $display("FAIL abort_0f_c%0d: tx %b done %b want %b 0",
                      n, tx_out, done, exp_bits[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_0f_done: got %b want 1", done); end
        @(posedge clk); #1;
    endtask

`ifdef REG8_SERIAL_TX_PARITY_EN
    task automatic test_parity();
        int exp7 [NBITS];
        int exp3 [NBITS];
        exp7 = '{0,1,1,1,0,0,0,0,0,1,1};
        exp3 = '{0,1,1,0,0,0,0,0,0,0,1};
        in_valid = 1'b1; d = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 44; n++) begin
            checks++;
            if (tx_out !== exp7[n/CPB][0] || done !== 1'b0)
                begin errors++; $display("FAIL par07_c%0d: tx %b done %b want %b 0", n, tx_out, done, exp7[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL par07_done: got %b want 1", done); end
        in_valid = 1'b1; d = 8'h03;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 44; n++) begin
            checks++;
            if (tx_out !== exp3[n/CPB][0] || done !== 1'b0)
                begin errors++; $display("FAIL par03_c%0d: tx %b done %b want %b 0", n, tx_out, done, exp3[n/CPB][0]); end
            @(posedge clk); #1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL par03_done: got %b want 1", done); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; d = 8'h00; in_valid2 = 1'b0; d2 = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_idle();
        test_frame_a5();
        test_msb_first();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef REG8_SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
